// File: rtl/divider_arbiter.sv
// divider_arbiter
// Round-robin sequencing front-end that lets two requesters share one 6-bit
// restoring divider. It accepts a dividend/divisor pair and drives the
// divider's start/In_bus load protocol (dividend, then divisor). It then
// waits for done and returns quotient/remainder to the requester that owns
// the job. Only one job is in flight at a time.
//
// Optional feature: define DIV_ZERO_CHECK_EN to short-circuit zero divisors.
// Such jobs skip the divider and return q='1, r=dividend, err=1.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req0_* / req1_*           requester operand handshake (valid/ready)
//   resp0_valid, resp1_valid  one-cycle result pulse to the job owner
//   resp_q, resp_r, resp_err  result registers, held until the next capture
//   div_start, div_in         divider start pulse and In_bus
//   div_done, div_q, div_r    divider completion and results
module divider_arbiter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_dividend,
  input  logic [W-1:0] req0_divisor,
  output logic         req0_ready,
  output logic         resp0_valid,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_dividend,
  input  logic [W-1:0] req1_divisor,
  output logic         req1_ready,
  output logic         resp1_valid,
  output logic [W-1:0] resp_q,
  output logic [W-1:0] resp_r,
  output logic         resp_err,
  output logic         div_start,
  output logic [W-1:0] div_in,
  input  logic         div_done,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r
);

  typedef enum logic [2:0] {IDLE, START, LOAD_DVS, WAIT, RESP} state_t;

  state_t       state, state_nxt;
  logic         last;
  logic         owner;
  logic [W-1:0] dvd, dvs;
  logic [W-1:0] res_q, res_r;
  logic         grant_any, grant_id;
  logic         div_zero;

`ifdef DIV_ZERO_CHECK_EN
  logic res_err;
  assign div_zero = (dvs == '0);
  assign resp_err = res_err;
`else
  assign div_zero = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Grants are only made in IDLE. On a tie, the requester that was not
  // served last wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE && !rst) begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) grant_id = ~last;
      else                          grant_id = req1_valid;
    end
  end

  assign req0_ready = grant_any & ~grant_id;
  assign req1_ready = grant_any &  grant_id;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_any) state_nxt = START;
      START:    state_nxt = div_zero ? RESP : LOAD_DVS;
      LOAD_DVS: state_nxt = WAIT;
      WAIT:     if (div_done) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_start   = (state == START) && !div_zero;
    resp0_valid = (state == RESP) && !owner;
    resp1_valid = (state == RESP) &&  owner;
    div_in      = '0;
    case (state)
      START:    div_in = dvd;
      LOAD_DVS: div_in = dvs;
      default:  div_in = '0;
    endcase
  end

  assign resp_q = res_q;
  assign resp_r = res_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
      dvd   <= '0;
      dvs   <= '0;
      res_q <= '0;
      res_r <= '0;
`ifdef DIV_ZERO_CHECK_EN
      res_err <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        owner <= grant_id;
        dvd   <= grant_id ? req1_dividend : req0_dividend;
        dvs   <= grant_id ? req1_divisor  : req0_divisor;
      end
      // RESP is always left after one cycle, so this fires once per job.
      if (state_nxt == RESP && state != RESP) last <= owner;
      if (state == WAIT && div_done) begin
        res_q <= div_q;
        res_r <= div_r;
`ifdef DIV_ZERO_CHECK_EN
        res_err <= 1'b0;
`endif
      end
`ifdef DIV_ZERO_CHECK_EN
      if (state == START && div_zero) begin
        res_q   <= '1;
        res_r   <= dvd;
        res_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Sequencing and arbitration front-end for the 6-bit restoring divider. Two independent requesters share one divider instance: the block accepts a dividend/divisor pair from one requester, drives the divider's start/In_bus load protocol, waits for done, then returns quotient and remainder to the owner. Round-robin arbitration between the two requesters; one division in flight at a time.

## Interface
- W, 6, operand/result width; must match the divider.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_dividend  input  W  requester 0 dividend.
- req0_divisor  input  W  requester 0 divisor.
- req0_ready  output  1  one-cycle accept pulse to requester 0.
- resp0_valid  output  1  one-cycle result pulse to requester 0.
- req1_valid, req1_dividend, req1_divisor, req1_ready, resp1_valid  as above for requester 1.
- resp_q  output  W  quotient of the completed job; valid with respN_valid.
- resp_r  output  W  remainder of the completed job; valid with respN_valid.
- resp_err  output  1  divide-by-zero flag; valid with respN_valid. Tied 0 without DIV_ZERO_CHECK_EN.
- div_start  output  1  start pulse to the divider.
- div_in  output  W  drives the divider In_bus.
- div_done  input  1  divider done.
- div_q  input  W  divider Q_bus.
- div_r  input  W  divider R_bus.

## Operation
- States: IDLE, START, LOAD_DVS, WAIT, RESP.
- IDLE: if any reqN_valid, grant per arbitration; assert reqN_ready for the granted requester in this cycle, latch its dividend, divisor, and owner id; next state START.
- Arbitration: round-robin pointer `last`. If both are valid, grant the requester that is not `last`. If only one is valid, grant it. `last` is updated to the owner when the job enters RESP.
- START: div_start=1, div_in=latched dividend; go to LOAD_DVS.
- LOAD_DVS: div_start=0, div_in=latched divisor; go to WAIT.
- WAIT: div_in=0. On div_done=1, capture div_q/div_r into the result registers; go to RESP.
- RESP: respN_valid=1 for the owner only; resp_q/resp_r/resp_err are held from capture until the next capture. Go to IDLE.
- Requesters must hold valid and operands stable until they see ready. Operands sampled at ready are the ones used.
- A request arriving during START..RESP waits; no grant is made outside IDLE.
- div_done outside WAIT is ignored.
- Reset (any cycle, including mid-job): state=IDLE, `last`=1 (so requester 0 wins the first tie), all outputs 0, latched operands/results 0; the in-flight job is dropped with no response. The divider shares rst and resets with it.

## Timing
- Accept (IDLE, ready=1) at cycle T; div_start at T+1; divisor on div_in at T+2; WAIT from T+3.
- If div_done is first seen high in cycle D, respN_valid is at D+1 and IDLE is at D+2.
- Back-to-back: the next ready is no earlier than D+2. Minimum issue interval is 5 cycles plus the divider run time.
- All outputs are registered state decodes. No combinational path from reqN_valid to anything except reqN_ready in IDLE.

## Configuration
- DIV_ZERO_CHECK_EN defined: in START, if the latched divisor==0, skip the divider (div_start stays 0) and go directly to RESP with resp_q=all ones (6'h3F), resp_r=dividend, resp_err=1; response at T+2. resp_err=0 for every nonzero divisor.
- DIV_ZERO_CHECK_EN undefined: a zero divisor is passed to the divider unchanged; the result is whatever the divider returns; resp_err is constant 0.

## Test plan
- Single job: req0 with 45/6 -> req0_ready 1 cycle, div_start 1 cycle later with div_in=45, then div_in=6; resp0_valid with resp_q=7, resp_r=3; resp1_valid stays 0.
- Simultaneous requests after reset: req0 17/5 and req1 63/8 -> req0 served first (q=3, r=2), then req1 (q=7, r=7); both requesters held valid -> they alternate 0,1,0,1.
- Operand hold: req1 changes its operands to 9/2 the cycle after ready -> the result still uses the originally sampled pair.
- Reset mid-WAIT: assert rst during WAIT -> all outputs 0 immediately, no respN_valid; the next request is served normally.
- DIV_ZERO_CHECK_EN on: req0 20/0 -> div_start never asserted; resp0_valid 2 cycles after ready with q=63, r=20, err=1. Macro off: div_start is asserted and err=0.
